// File: rtl/s13207_seq_pkg.sv
// ---------------------------------------------------------------------------
// s13207_seq_pkg
// Shared types and constants for the s13207 g9297 select sequencer:
//   - state_t       : sequencer state encoding
//   - CTL_BANK0/1/2 : {g86,g83,g80,g52} patterns for cone banks 0..2
//   - EN_ACTIVE/IDLE: {g44,g41,g45,g42,g55} patterns while scanning / idle
//   - ctl_for_mode(): bank select to ctl pattern lookup
// ---------------------------------------------------------------------------
package s13207_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] CTL_BANK0     = 4'b0010;
    localparam logic [3:0] CTL_BANK1     = 4'b0000;
    localparam logic [3:0] CTL_BANK2     = 4'b1111;
    localparam logic [3:0] CTL_IDLE      = 4'b0000;

    localparam logic [4:0] EN_ACTIVE     = 5'b10000;
    localparam logic [4:0] EN_IDLE       = 5'b00000;

    localparam logic [1:0] MODE_RESERVED = 2'd3;

    // Mode 3 is reserved and never reaches this lookup during a scan;
    // it maps to the idle pattern so the function is total.
    function automatic logic [3:0] ctl_for_mode(input logic [1:0] m);
        logic [3:0] v;
        case (m)
            2'd0:    v = CTL_BANK0;
            2'd1:    v = CTL_BANK1;
            2'd2:    v = CTL_BANK2;
            default: v = CTL_IDLE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/s13207_next_code.sv
// ---------------------------------------------------------------------------
// s13207_next_code
// Combinational priority search: lowest set mask bit strictly above the
// current code. With i_first = 1 every bit is eligible, which is the
// "current = -1" case used to pick the first code of a scan.
// Ports:
//   i_mask  [15:0] code-enable mask
//   i_cur   [3:0]  current code
//   i_first        search from below code 0
//   o_found        a candidate exists
//   o_next  [3:0]  the candidate (0 when none)
// ---------------------------------------------------------------------------
module s13207_next_code
    import s13207_seq_pkg::*;
(
    input  logic [15:0] i_mask,
    input  logic [3:0]  i_cur,
    input  logic        i_first,
    output logic        o_found,
    output logic [3:0]  o_next
);

    logic [15:0] w_eligible;
    logic [15:0] w_onehot;

    // Keep only mask bits above the current code (or all of them on first pick)
    always_comb begin
        w_eligible = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            w_eligible[i] = i_mask[i] & (i_first | (4'(i) > i_cur));
        end
    end

    // Isolate the lowest eligible bit and encode it
    always_comb begin
        w_onehot = w_eligible & (~w_eligible + 16'd1);
        o_found  = |w_eligible;
        o_next   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            o_next = o_next | ({4{w_onehot[i]}} & 4'(i));
        end
    end

endmodule

// File: rtl/s13207_sel_sequencer.sv
// ---------------------------------------------------------------------------
// s13207_sel_sequencer
// Walks the g9297 cone through the masked 4-bit select codes, lets each code
// settle for SETTLE_CYCLES cycles and captures the cone output into result.
// Ports:
//   CK, RST          clock, asynchronous active-high reset
//   start, abort     host scan request / cancel (abort wins)
//   mode [1:0]       cone bank (3 reserved -> err pulse)
//   sel_mask [15:0]  codes to visit, latched on start acceptance
//   obs_in           g9297 value, captured at the end of SAMPLE
//   sel, ctl, en_grp, g62_drv   static cone drives (registered)
//   busy, done, err, aborted    host handshake (registered)
//   result [15:0], count [4:0]  capture word and number of samples
// ---------------------------------------------------------------------------
module s13207_sel_sequencer
    import s13207_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
)
(
    input  logic        CK,
    input  logic        RST,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode,
    input  logic [15:0] sel_mask,
    input  logic        obs_in,
    output logic [3:0]  sel,
    output logic [3:0]  ctl,
    output logic [4:0]  en_grp,
    output logic        g62_drv,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        aborted,
    output logic [15:0] result,
    output logic [4:0]  count
);

    // SETUP loads SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES cycles
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam bit         SKIP_SETTLE = (SETTLE_CYCLES == 0);

    state_t      r_state;
    logic [15:0] r_mask;
    logic [1:0]  r_mode;
    logic [3:0]  r_settle;
    logic [3:0]  r_sel;
    logic [3:0]  r_ctl;
    logic [4:0]  r_en_grp;
    logic        r_g62;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_aborted;
    logic [15:0] r_result;
    logic [4:0]  r_count;

    logic [15:0] w_src_mask;
    logic        w_first;
    logic        w_found;
    logic [3:0]  w_next;

    // In IDLE the search runs on the live mask from below code 0; otherwise
    // it continues from the current code in the latched mask.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_src_mask = sel_mask;
            w_first    = 1'b1;
        end else begin
            w_src_mask = r_mask;
            w_first    = 1'b0;
        end
    end

    s13207_next_code u_next_code (
        .i_mask  (w_src_mask),
        .i_cur   (r_sel),
        .i_first (w_first),
        .o_found (w_found),
        .o_next  (w_next)
    );

    // Sequencer state machine with all outputs registered
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_mask    <= 16'h0000;
            r_mode    <= 2'd0;
            r_settle  <= 4'd0;
            r_sel     <= 4'd0;
            r_ctl     <= CTL_IDLE;
            r_en_grp  <= EN_IDLE;
            r_g62     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
            r_result  <= 16'h0000;
            r_count   <= 5'd0;
        end else begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state   <= ST_IDLE;
                r_settle  <= 4'd0;
                r_sel     <= 4'd0;
                r_ctl     <= CTL_IDLE;
                r_en_grp  <= EN_IDLE;
                r_g62     <= 1'b0;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
                r_result  <= 16'h0000;
                r_count   <= 5'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // abort held with start in IDLE suppresses the request silently
                        if (start && !abort) begin
                            if (mode == MODE_RESERVED) begin
                                r_err <= 1'b1;
                            end else begin
                                r_mode   <= mode;
                                r_mask   <= sel_mask;
                                r_result <= 16'h0000;
                                r_count  <= 5'd0;
                                r_busy   <= 1'b1;
                                if (w_found) begin
                                    r_state  <= ST_SETUP;
                                    r_sel    <= w_next;
                                    r_ctl    <= ctl_for_mode(mode);
                                    r_en_grp <= EN_ACTIVE;
                                    r_g62    <= 1'b1;
                                end else begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_SETUP: begin
                        if (SKIP_SETTLE) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_state  <= ST_SETTLE;
                            r_settle <= SETTLE_LOAD;
                        end
                    end
                    ST_SETTLE: begin
                        if (r_settle == 4'd0) begin
                            r_state <= ST_SAMPLE;
                        end else begin
                            r_settle <= r_settle - 4'd1;
                        end
                    end
                    ST_SAMPLE: begin
                        r_result[r_sel] <= obs_in;
                        r_count         <= r_count + 5'd1;
                        if (w_found) begin
                            r_state <= ST_SETUP;
                            r_sel   <= w_next;
                            r_ctl   <= ctl_for_mode(r_mode);
                        end else begin
                            r_state  <= ST_DONE;
                            r_sel    <= 4'd0;
                            r_ctl    <= CTL_IDLE;
                            r_en_grp <= EN_IDLE;
                            r_g62    <= 1'b0;
                            r_done   <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sel    <= 4'd0;
                        r_ctl    <= CTL_IDLE;
                        r_en_grp <= EN_IDLE;
                        r_g62    <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sel     = r_sel;
    assign ctl     = r_ctl;
    assign en_grp  = r_en_grp;
    assign g62_drv = r_g62;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign aborted = r_aborted;
    assign result  = r_result;
    assign count   = r_count;

endmodule
